enable_period_monitor: RTL and testbench

- Receiving end of the clock-enable strobe interface.
- Samples a single-cycle enable strobe, such as the output of clock_enable_param, and measures the interval between strobes in clk cycles.
- Declares lock after N consecutive in-tolerance periods, and flags a fault on a bad or missing strobe once locked.
- Sits beside camera and IPM pipeline stages that depend on enable cadence; gives a health signal and a measured period for debug.

---
 rtl/enable_period_monitor_pkg.sv | 14 +
 rtl/enable_period_monitor_sat_counter.sv | 24 ++
 rtl/enable_period_monitor.sv | 130 +++++++++++++
 tb/tb_enable_period_monitor.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/enable_period_monitor_pkg.sv
// Shared definitions for the enable-strobe period monitor: state encoding
// and the width of the consecutive-match counter.
package enable_period_monitor_pkg;

    localparam int LOCK_CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2,
        FAULT   = 2'd3
    } state_t;

endpackage

// File: rtl/enable_period_monitor_sat_counter.sv
// Interval counter: synchronous load-to-1 on a strobe, otherwise counts up
// and holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] MAX = '1;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= WIDTH'(1);
        end else if (count != MAX) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/enable_period_monitor.sv
// Measures the spacing of a single-cycle enable strobe, declares lock after
// LOCK_COUNT in-tolerance periods and faults on a bad or missing strobe.
//   state   | meaning
//   IDLE    | no strobe seen since reset or fault clear
//   MEASURE | counting consecutive in-tolerance periods
//   LOCKED  | cadence good; any bad or late strobe faults
//   FAULT   | cadence lost; waits for clear_fault
module enable_period_monitor
    import enable_period_monitor_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int EXPECTED   = 3,
    parameter int TOL        = 0,
    parameter int LOCK_COUNT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             clear_fault,
    output logic [WIDTH-1:0] period,
    output logic             period_valid,
    output logic             locked,
    output logic             fault
);

    if (EXPECTED + TOL >= (2 ** WIDTH) - 1) begin : g_bad_expected
        $fatal(1, "enable_period_monitor: EXPECTED+TOL must be below the saturation value");
    end
    if (LOCK_COUNT < 1 || LOCK_COUNT > 15) begin : g_bad_lock_count
        $fatal(1, "enable_period_monitor: LOCK_COUNT must be in 1..15");
    end

    localparam logic [WIDTH:0]            EXP_W   = (WIDTH+1)'(EXPECTED);
    localparam logic [WIDTH:0]            TOL_W   = (WIDTH+1)'(TOL);
    localparam logic [WIDTH:0]            LIMIT_W = (WIDTH+1)'(EXPECTED + TOL);
    localparam logic [WIDTH-1:0]          CNT_MAX = '1;
    localparam logic [LOCK_CNT_W-1:0]     LOCK_N  = LOCK_CNT_W'(LOCK_COUNT);

    state_t                  state;
    state_t                  state_nxt;
    logic [WIDTH-1:0]        cnt;
    logic [WIDTH:0]          cnt_ext;
    logic [WIDTH:0]          dev;
    logic [LOCK_CNT_W-1:0]   match_cnt;
    logic [LOCK_CNT_W-1:0]   match_nxt;
    logic [LOCK_CNT_W-1:0]   match_inc;
    logic                    is_match;
    logic                    missing;
    logic                    capture;

    sat_counter #(.WIDTH(WIDTH)) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .load  (enable),
        .count (cnt)
    );

    // A saturated count means the true interval is unknown, so it never matches.
    assign cnt_ext   = {1'b0, cnt};
    assign dev       = (cnt_ext >= EXP_W) ? (cnt_ext - EXP_W) : (EXP_W - cnt_ext);
    assign is_match  = (dev <= TOL_W) && (cnt != CNT_MAX);
    assign missing   = !enable && (cnt_ext == LIMIT_W);
    assign match_inc = match_cnt + 1'b1;

    always_comb begin
        state_nxt = state;
        match_nxt = match_cnt;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                if (enable) begin
                    state_nxt = MEASURE;
                    match_nxt = '0;
                end
            end
            MEASURE: begin
                if (enable) begin
                    capture = 1'b1;
                    if (is_match) begin
                        match_nxt = match_inc;
                        if (match_inc == LOCK_N) state_nxt = LOCKED;
                    end else begin
                        match_nxt = '0;
                    end
                end
            end
            LOCKED: begin
                if (enable) begin
                    capture = 1'b1;
                    if (!is_match) state_nxt = FAULT;
                end else if (missing) begin
                    state_nxt = FAULT;
                end
            end
            FAULT: begin
                // A strobe coinciding with the clear restarts measurement
                // rather than reporting a period across the fault.
                if (clear_fault) begin
                    match_nxt = '0;
                    state_nxt = enable ? MEASURE : IDLE;
                end else if (enable) begin
                    capture = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                match_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            match_cnt    <= '0;
            period       <= '0;
            period_valid <= 1'b0;
            locked       <= 1'b0;
            fault        <= 1'b0;
        end else begin
            state        <= state_nxt;
            match_cnt    <= match_nxt;
            period_valid <= capture;
            if (capture) period <= cnt;
            locked       <= (state_nxt == LOCKED);
            fault        <= (state_nxt == FAULT);
        end
    end

endmodule

// File: tb/tb_enable_period_monitor.sv
// Bench for enable_period_monitor: directed scenarios plus randomized strobe
// cadences checked against a timestamp-based reference model.
module tb_enable_period_monitor;
    import enable_period_monitor_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst0 = 1'b1, en0 = 1'b0, clr0 = 1'b0;
    logic       rst1 = 1'b1, en1 = 1'b0, clr1 = 1'b0;
    logic [7:0] period0, period1;
    logic       pv0, pv1, lk0, lk1, ft0, ft1;

    enable_period_monitor dut (
        .clk(clk), .rst(rst0), .enable(en0), .clear_fault(clr0),
        .period(period0), .period_valid(pv0), .locked(lk0), .fault(ft0)
    );

    enable_period_monitor #(.TOL(1)) dut1 (
        .clk(clk), .rst(rst1), .enable(en1), .clear_fault(clr1),
        .period(period1), .period_valid(pv1), .locked(lk1), .fault(ft1)
    );

    wire [10:0] obs0 = {period0, pv0, lk0, ft0};
    wire [10:0] obs1 = {period1, pv1, lk1, ft1};

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: intervals come from strobe timestamps, not a counter.
    localparam int M_IDLE = 0, M_MEAS = 1, M_LOCK = 2, M_FAULT = 3;
    localparam int EXP = 3;
    int m_mode[2], m_match[2], m_last[2], m_period[2];
    bit m_pv[2];
    int cyc = 0;

    function automatic bit in_tol(input int iv, input int tol);
        int d;
        d = (iv > EXP) ? iv - EXP : EXP - iv;
        return (iv != 255) && (d <= tol);
    endfunction

    task automatic mdl(input int idx, input bit e, input bit c, input bit r);
        int tol, iv;
        tol = idx;
        iv  = cyc - m_last[idx];
        if (iv > 255) iv = 255;
        if (r) begin
            m_mode[idx] = M_IDLE; m_match[idx] = 0; m_period[idx] = 0;
            m_pv[idx] = 0; m_last[idx] = cyc;
            return;
        end
        m_pv[idx] = 0;
        case (m_mode[idx])
            M_IDLE: if (e) begin m_mode[idx] = M_MEAS; m_match[idx] = 0; end
            M_MEAS: if (e) begin
                m_pv[idx] = 1; m_period[idx] = iv;
                if (in_tol(iv, tol)) begin
                    m_match[idx]++;
                    if (m_match[idx] == 4) m_mode[idx] = M_LOCK;
                end else m_match[idx] = 0;
            end
            M_LOCK: if (e) begin
                m_pv[idx] = 1; m_period[idx] = iv;
                if (!in_tol(iv, tol)) m_mode[idx] = M_FAULT;
            end else if (iv == EXP + tol) m_mode[idx] = M_FAULT;
            default: if (c) begin
                m_match[idx] = 0;
                m_mode[idx] = e ? M_MEAS : M_IDLE;
            end else if (e) begin
                m_pv[idx] = 1; m_period[idx] = iv;
            end
        endcase
        if (e) m_last[idx] = cyc;
    endtask

    function automatic logic [10:0] exp_vec(input int idx);
        logic [7:0] p;
        p = m_period[idx][7:0];
        return {p, m_pv[idx], m_mode[idx] == M_LOCK, m_mode[idx] == M_FAULT};
    endfunction

    // One clock: drive instance idx, hold the other in reset, then sample #1 after the edge.
    task automatic step(input int idx, input bit e, input bit c, input bit r);
        if (idx == 0) begin
            en0 = e; clr0 = c; rst0 = r; en1 = 0; clr1 = 0; rst1 = 1;
        end else begin
            en1 = e; clr1 = c; rst1 = r; en0 = 0; clr0 = 0; rst0 = 1;
        end
        @(posedge clk);
        mdl(0, en0, clr0, rst0);
        mdl(1, en1, clr1, rst1);
        cyc++;
        #1;
    endtask

    task automatic test_reset();
        step(0, 1, 0, 1);
        step(0, 1, 1, 1);
        step(0, 0, 0, 1);
        n_cmp++;
        if (obs0 !== 11'd0 || dut.state !== IDLE) begin
            n_bad++;
            $display("FAIL reset: got outs=%h state=%0d, want outs=0 state=IDLE", obs0, dut.state);
        end
    endtask

    task automatic test_lock();
        bit lk_exp;
        step(0, 0, 0, 1);
        step(0, 1, 0, 0);
        n_cmp++;
        if (pv0 !== 1'b0 || dut.state !== MEASURE) begin
            n_bad++;
            $display("FAIL lock_first: got pv=%b state=%0d, want pv=0 state=MEASURE", pv0, dut.state);
        end
        for (int k = 1; k <= 4; k++) begin
            step(0, 0, 0, 0);
            step(0, 0, 0, 0);
            step(0, 1, 0, 0);
            lk_exp = (k == 4);
            n_cmp++;
            if ({period0, pv0, lk0, ft0} !== {8'd3, 1'b1, lk_exp, 1'b0}) begin
                n_bad++;
                $display("FAIL lock k=%0d: got period=%0d pv=%b locked=%b fault=%b, want 3 1 %b 0",
                         k, period0, pv0, lk0, ft0, lk_exp);
            end
            n_cmp++;
            if (obs0 !== exp_vec(0)) begin
                n_bad++;
                $display("FAIL lock_model k=%0d: got %h want %h", k, obs0, exp_vec(0));
            end
        end
        step(0, 0, 0, 0);
        n_cmp++;
        if (pv0 !== 1'b0 || lk0 !== 1'b1) begin
            n_bad++;
            $display("FAIL lock_hold: got pv=%b locked=%b, want pv=0 locked=1", pv0, lk0);
        end
    endtask

    // Continues from LOCKED with the last strobe two cycles ago... re-sync first.
    task automatic test_missing_strobe();
        step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        n_cmp++;
        if (lk0 !== 1'b1 || ft0 !== 1'b0) begin
            n_bad++;
            $display("FAIL missing_before: got locked=%b fault=%b, want 1 0", lk0, ft0);
        end
        step(0, 0, 0, 0);
        n_cmp++;
        if (lk0 !== 1'b0 || ft0 !== 1'b1) begin
            n_bad++;
            $display("FAIL missing_edge: got locked=%b fault=%b, want 0 1", lk0, ft0);
        end
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        n_cmp++;
        if ({period0, pv0, ft0} !== {8'd6, 1'b1, 1'b1}) begin
            n_bad++;
            $display("FAIL fault_period: got period=%0d pv=%b fault=%b, want 6 1 1", period0, pv0, ft0);
        end
    endtask

    // Continues from FAULT.
    task automatic test_recovery();
        step(0, 1, 1, 0);
        n_cmp++;
        if (dut.state !== MEASURE || pv0 !== 1'b0 || ft0 !== 1'b0 || lk0 !== 1'b0) begin
            n_bad++;
            $display("FAIL recover_clear: got state=%0d pv=%b fault=%b, want MEASURE 0 0", dut.state, pv0, ft0);
        end
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        n_cmp++;
        if (period0 !== 8'd3 || pv0 !== 1'b1 || dut.match_cnt !== 4'd1) begin
            n_bad++;
            $display("FAIL recover_first: got period=%0d pv=%b match=%0d, want 3 1 1", period0, pv0, dut.match_cnt);
        end
        for (int k = 0; k < 3; k++) begin
            step(0, 0, 0, 0); step(0, 0, 0, 0); step(0, 1, 0, 0);
        end
        n_cmp++;
        if (lk0 !== 1'b1) begin
            n_bad++;
            $display("FAIL relock: got locked=%b, want 1", lk0);
        end
        step(0, 0, 0, 0); step(0, 0, 0, 0); step(0, 0, 0, 0);
        step(0, 0, 0, 0); step(0, 0, 0, 0);
        n_cmp++;
        if (obs0 !== exp_vec(0) || ft0 !== 1'b1) begin
            n_bad++;
            $display("FAIL late_strobe: got %h want %h (fault=1)", obs0, exp_vec(0));
        end
        step(0, 0, 1, 0);
        n_cmp++;
        if (dut.state !== IDLE || ft0 !== 1'b0 || dut.match_cnt !== 4'd0) begin
            n_bad++;
            $display("FAIL clear_idle: got state=%0d fault=%b match=%0d, want IDLE 0 0", dut.state, ft0, dut.match_cnt);
        end
    endtask

    task automatic test_reset_mid_lock();
        step(0, 0, 0, 1);
        step(0, 1, 0, 0);
        for (int k = 0; k < 4; k++) begin
            step(0, 0, 0, 0); step(0, 0, 0, 0); step(0, 1, 0, 0);
        end
        step(0, 0, 0, 0);
        step(0, 1, 1, 1);
        n_cmp++;
        if (obs0 !== 11'd0 || dut.state !== IDLE) begin
            n_bad++;
            $display("FAIL reset_mid_lock: got outs=%h state=%0d, want 0 IDLE", obs0, dut.state);
        end
        step(0, 0, 0, 0);
        n_cmp++;
        if (obs0 !== 11'd0) begin
            n_bad++;
            $display("FAIL reset_after: got outs=%h, want 0", obs0);
        end
    endtask

    task automatic test_continuous();
        step(0, 0, 0, 1);
        step(0, 1, 0, 0);
        for (int k = 0; k < 20; k++) begin
            step(0, 1, 0, 0);
            n_cmp++;
            if ({period0, pv0, lk0, ft0} !== {8'd1, 1'b1, 1'b0, 1'b0}) begin
                n_bad++;
                $display("FAIL continuous k=%0d: got period=%0d pv=%b locked=%b, want 1 1 0", k, period0, pv0, lk0);
            end
        end
    endtask

    task automatic test_alternating();
        int gap;
        step(0, 0, 0, 1);
        step(0, 1, 0, 0);
        for (int k = 0; k < 10; k++) begin
            gap = (k % 2 == 0) ? 3 : 4;
            for (int j = 1; j < gap; j++) step(0, 0, 0, 0);
            step(0, 1, 0, 0);
            n_cmp++;
            if (period0 !== 8'(gap) || pv0 !== 1'b1 || lk0 !== 1'b0 ||
                dut.match_cnt !== 4'((gap == 3) ? 1 : 0)) begin
                n_bad++;
                $display("FAIL alternating k=%0d: got period=%0d locked=%b match=%0d, want period=%0d locked=0",
                         k, period0, lk0, dut.match_cnt, gap);
            end
        end
    endtask

    task automatic test_saturation();
        step(0, 0, 0, 1);
        step(0, 1, 0, 0);
        for (int k = 0; k < 300; k++) step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        n_cmp++;
        if (period0 !== 8'd255 || pv0 !== 1'b1 || dut.state !== MEASURE || dut.match_cnt !== 4'd0) begin
            n_bad++;
            $display("FAIL saturation: got period=%0d pv=%b state=%0d match=%0d, want 255 1 MEASURE 0",
                     period0, pv0, dut.state, dut.match_cnt);
        end
    endtask

    task automatic test_tol1();
        int gaps[5] = '{2, 3, 4, 3, 5};
        bit lk_exp, ft_exp;
        step(1, 0, 0, 1);
        step(1, 1, 0, 0);
        for (int k = 0; k < 5; k++) begin
            for (int j = 1; j < gaps[k]; j++) step(1, 0, 0, 0);
            step(1, 1, 0, 0);
            lk_exp = (k == 3);
            ft_exp = (k == 4);
            n_cmp++;
            if ({period1, pv1, lk1, ft1} !== {8'(gaps[k]), 1'b1, lk_exp, ft_exp}) begin
                n_bad++;
                $display("FAIL tol1 k=%0d: got period=%0d pv=%b locked=%b fault=%b, want %0d 1 %b %b",
                         k, period1, pv1, lk1, ft1, gaps[k], lk_exp, ft_exp);
            end
        end
    endtask

    task automatic test_random(input int idx, input int cycles);
        int gap_left, g;
        bit e, c, r;
        logic [10:0] obs;
        gap_left = 0;
        step(idx, 0, 0, 1);
        for (int k = 0; k < cycles; k++) begin
            e = 0;
            if (gap_left == 0) begin
                e = 1;
                if ($urandom_range(0, 4) != 0) g = (idx == 0) ? 3 : $urandom_range(2, 4);
                else g = $urandom_range(1, 6);
                gap_left = g - 1;
            end else gap_left--;
            c = ($urandom_range(0, 7) == 0);
            r = ($urandom_range(0, 199) == 0);
            step(idx, e, c, r);
            obs = (idx == 0) ? obs0 : obs1;
            n_cmp++;
            if (obs !== exp_vec(idx)) begin
                n_bad++;
                $display("FAIL random dut%0d cyc=%0d: got %h want %h", idx, cyc, obs, exp_vec(idx));
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            m_mode[i] = M_IDLE; m_match[i] = 0; m_last[i] = 0; m_period[i] = 0; m_pv[i] = 0;
        end
        test_reset();
        test_lock();
        test_missing_strobe();
        test_recovery();
        test_reset_mid_lock();
        test_continuous();
        test_alternating();
        test_saturation();
        test_tol1();
        test_random(0, 1500);
        test_random(1, 1500);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
